// File: rtl/amba3_apb_cam_slave_if.sv
// APB bus bundle for the CAM scratch-memory completer.
interface amba3_apb_cam_slave_if #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
);
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDR_SIZE-1:0] paddr;
  logic [DATA_SIZE-1:0] pwdata;
  logic [DATA_SIZE-1:0] prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/amba3_apb_cam_slave.sv
// AMBA 3 APB completer backed by a fully-associative {valid, tag, data} store.
// Full 32-bit addresses are keys; a write miss on a full store returns pslverr.
module amba3_apb_cam_slave #(
  parameter int ADDR_SIZE   = 32,
  parameter int DATA_SIZE   = 32,
  parameter int ENTRIES     = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  preset,
  amba3_apb_cam_slave_if.slave  apb,
  output logic                  full
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W = 4;

  logic [CNT_W-1:0]     r_cnt;
  logic [ENTRIES-1:0]   r_valid;
  logic                 r_full;
  logic [ADDR_SIZE-1:0] r_tag  [ENTRIES];
  logic [DATA_SIZE-1:0] r_data [ENTRIES];

  logic                 w_access;
  logic                 w_ready;
  logic                 w_hit;
  logic                 w_free;
  logic [IDX_W-1:0]     w_hit_idx;
  logic [IDX_W-1:0]     w_free_idx;
  logic [IDX_W-1:0]     w_wr_idx;
  logic                 w_wr_en;
  logic [ENTRIES-1:0]   w_valid_nxt;

  // Gating with preset forces all completion outputs low while reset is held.
  assign w_access = apb.psel & apb.penable & ~preset;
  assign w_ready  = w_access & (r_cnt == CNT_W'(WAIT_STATES));

  // Descending scan leaves the lowest-index free slot in w_free_idx.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_valid[i] && (r_tag[i] == apb.paddr)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  assign w_wr_en  = w_ready & apb.pwrite & (w_hit | w_free);
  assign w_wr_idx = w_hit ? w_hit_idx : w_free_idx;

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_wr_en) w_valid_nxt[w_wr_idx] = 1'b1;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_cnt   <= '0;
      r_valid <= '0;
      r_full  <= 1'b0;
    end else begin
      // Not-ready access implies r_cnt is still below WAIT_STATES.
      if (!apb.psel || w_ready)
        r_cnt <= '0;
      else if (w_access)
        r_cnt <= r_cnt + 1'b1;
      r_valid <= w_valid_nxt;
      r_full  <= &w_valid_nxt;
    end
  end

  always_ff @(posedge pclk) begin
    if (w_wr_en) begin
      r_tag[w_wr_idx]  <= apb.paddr;
      r_data[w_wr_idx] <= apb.pwdata;
    end
  end

  assign apb.pready  = w_ready;
  assign apb.pslverr = w_ready & apb.pwrite & ~w_hit & ~w_free;
  assign apb.prdata  = (w_ready & ~apb.pwrite & w_hit) ? r_data[w_hit_idx] : '0;
  assign full        = r_full;

endmodule

// File: tb/tb_amba3_apb_cam_slave.sv
// Bench for amba3_apb_cam_slave: a zero-wait and a three-wait instance checked
// against associative-array models of the sparse store.
module tb_amba3_apb_cam_slave;

  localparam int ENTRIES = 16;

  logic        pclk = 1'b0;
  logic        preset;
  logic        r_sel;
  logic        m_psel, m_penable, m_pwrite;
  logic [31:0] m_paddr, m_pwdata;
  logic        full0, full3;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m0 [logic [31:0]];
  logic [31:0] m3 [logic [31:0]];

  always #5 pclk = ~pclk;

  amba3_apb_cam_slave_if #(.ADDR_SIZE(32), .DATA_SIZE(32)) if0 ();
  amba3_apb_cam_slave_if #(.ADDR_SIZE(32), .DATA_SIZE(32)) if3 ();

  assign if0.psel    = m_psel & ~r_sel;
  assign if0.penable = m_penable;
  assign if0.pwrite  = m_pwrite;
  assign if0.paddr   = m_paddr;
  assign if0.pwdata  = m_pwdata;
  assign if3.psel    = m_psel & r_sel;
  assign if3.penable = m_penable;
  assign if3.pwrite  = m_pwrite;
  assign if3.paddr   = m_paddr;
  assign if3.pwdata  = m_pwdata;

  amba3_apb_cam_slave #(.ADDR_SIZE(32), .DATA_SIZE(32), .ENTRIES(ENTRIES), .WAIT_STATES(0)) u0 (
    .pclk(pclk), .preset(preset), .apb(if0), .full(full0));
  amba3_apb_cam_slave #(.ADDR_SIZE(32), .DATA_SIZE(32), .ENTRIES(ENTRIES), .WAIT_STATES(3)) u3 (
    .pclk(pclk), .preset(preset), .apb(if3), .full(full3));

  // Reference model: a store of at most ENTRIES keys; returns expected pslverr.
  function automatic bit mdl_write(bit sel, logic [31:0] a, logic [31:0] d);
    if (!sel) begin
      if (m0.exists(a) || m0.num() < ENTRIES) begin m0[a] = d; return 1'b0; end
    end else begin
      if (m3.exists(a) || m3.num() < ENTRIES) begin m3[a] = d; return 1'b0; end
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] mdl_read(bit sel, logic [31:0] a);
    if (!sel) return m0.exists(a) ? m0[a] : 32'h0;
    return m3.exists(a) ? m3[a] : 32'h0;
  endfunction

  task automatic idle(input int n);
    m_psel    = 1'b0;
    m_penable = 1'b0;
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  // One transfer; returns at 1ns after the completion edge with psel still high.
  task automatic xfer(input bit sel, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err, output int cyc);
    bit done;
    done = 1'b0;
    rd = '0; err = 1'b0; cyc = 0;
    r_sel = sel; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr; m_paddr = a; m_pwdata = d;
    @(posedge pclk); #1;
    m_penable = 1'b1;
    while (!done && cyc < 64) begin
      @(negedge pclk);
      cyc++;
      if (sel ? if3.pready : if0.pready) begin
        rd   = sel ? if3.prdata : if0.prdata;
        err  = sel ? if3.pslverr : if0.pslverr;
        done = 1'b1;
      end
    end
    @(posedge pclk); #1;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL xfer_timeout addr=%h got no pready, required pready within 64 cycles", a);
    end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    r_sel = 1'b0; m_psel = 1'b1; m_penable = 1'b1; m_pwrite = 1'b0;
    m_paddr = 32'h0; m_pwdata = 32'h0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    n_tests++;
    if ({if0.pready, if0.pslverr, if3.pready, if3.pslverr} !== 4'b0) begin
      n_fail++; $display("FAIL reset_handshake got %b required 0000",
        {if0.pready, if0.pslverr, if3.pready, if3.pslverr});
    end
    n_tests++;
    if ((if0.prdata | if3.prdata) !== 32'h0) begin
      n_fail++; $display("FAIL reset_prdata got %h/%h required 0", if0.prdata, if3.prdata);
    end
    n_tests++;
    if ({full0, full3} !== 2'b00) begin
      n_fail++; $display("FAIL reset_full got %b required 00", {full0, full3});
    end
    @(posedge pclk); #1;
    idle(1);
    preset = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    logic [31:0] addrs [4] = '{32'h0, 32'h3, 32'h11, 32'h18};
    logic [31:0] datas [4] = '{32'h4, 32'h8, 32'h14, 32'h1C};
    logic [31:0] rd; logic err; int cyc; bit exp_err;
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 10));
      exp_err = mdl_write(1'b0, addrs[i], datas[i]);
      xfer(1'b0, 1'b1, addrs[i], datas[i], rd, err, cyc);
      n_tests++;
      if (err !== exp_err || cyc != 1) begin
        n_fail++; $display("FAIL basic_write a=%h got err=%b cyc=%0d required err=%b cyc=1", addrs[i], err, cyc, exp_err);
      end
    end
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 10));
      xfer(1'b0, 1'b0, addrs[i], 32'h0, rd, err, cyc);
      n_tests++;
      if (rd !== mdl_read(1'b0, addrs[i]) || err !== 1'b0 || cyc != 1) begin
        n_fail++; $display("FAIL basic_read a=%h got %h err=%b cyc=%0d required %h err=0 cyc=1",
          addrs[i], rd, err, cyc, mdl_read(1'b0, addrs[i]));
      end
    end
    idle(1);
  endtask

  task automatic test_overwrite_alias();
    logic [31:0] wa [5] = '{32'h40, 32'h83, 32'h18, 32'h00000003, 32'h80000003};
    logic [31:0] wd [5] = '{32'h12345678, 32'h40506070, 32'h22446688, 32'hA, 32'hB};
    logic [31:0] ra [5] = '{32'h18, 32'h40, 32'h83, 32'h00000003, 32'h80000003};
    logic [31:0] rd; logic err; int cyc; bit exp_err;
    for (int i = 0; i < 5; i++) begin
      exp_err = mdl_write(1'b0, wa[i], wd[i]);
      xfer(1'b0, 1'b1, wa[i], wd[i], rd, err, cyc);
      n_tests++;
      if (err !== exp_err) begin
        n_fail++; $display("FAIL ovw_write a=%h got err=%b required %b", wa[i], err, exp_err);
      end
    end
    for (int i = 0; i < 5; i++) begin
      xfer(1'b0, 1'b0, ra[i], 32'h0, rd, err, cyc);
      n_tests++;
      if (rd !== mdl_read(1'b0, ra[i]) || err !== 1'b0) begin
        n_fail++; $display("FAIL ovw_read a=%h got %h err=%b required %h err=0", ra[i], rd, err, mdl_read(1'b0, ra[i]));
      end
    end
    idle(1);
    n_tests++;
    if (full0 !== 1'b0) begin
      n_fail++; $display("FAIL ovw_full got %b required 0", full0);
    end
  endtask

  task automatic test_capacity();
    logic [31:0] a, d, rd; logic err; int cyc; bit exp_err;
    while (m0.num() < ENTRIES) begin
      a = $urandom;
      if (m0.exists(a)) continue;
      d = $urandom;
      exp_err = mdl_write(1'b0, a, d);
      xfer(1'b0, 1'b1, a, d, rd, err, cyc);
      n_tests++;
      if (err !== exp_err || full0 !== (m0.num() == ENTRIES)) begin
        n_fail++; $display("FAIL cap_fill a=%h got err=%b full=%b required err=%b full=%b",
          a, err, full0, exp_err, m0.num() == ENTRIES);
      end
    end
    do a = $urandom; while (m0.exists(a));
    exp_err = mdl_write(1'b0, a, 32'hBAD0BAD0);
    xfer(1'b0, 1'b1, a, 32'hBAD0BAD0, rd, err, cyc);
    n_tests++;
    if (err !== exp_err || exp_err !== 1'b1 || full0 !== 1'b1) begin
      n_fail++; $display("FAIL cap_overflow got err=%b full=%b required err=1 full=1", err, full0);
    end
    xfer(1'b0, 1'b0, a, 32'h0, rd, err, cyc);
    n_tests++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      n_fail++; $display("FAIL cap_unwritten got %h err=%b required 0 err=0", rd, err);
    end
    exp_err = mdl_write(1'b0, 32'h18, 32'h5A5A0018);
    xfer(1'b0, 1'b1, 32'h18, 32'h5A5A0018, rd, err, cyc);
    n_tests++;
    if (err !== exp_err || exp_err !== 1'b0) begin
      n_fail++; $display("FAIL cap_existing got err=%b required 0", err);
    end
    foreach (m0[k]) begin
      xfer(1'b0, 1'b0, k, 32'h0, rd, err, cyc);
      n_tests++;
      if (rd !== m0[k] || err !== 1'b0) begin
        n_fail++; $display("FAIL cap_readback a=%h got %h err=%b required %h err=0", k, rd, err, m0[k]);
      end
    end
    idle(1);
  endtask

  task automatic test_wait3();
    logic [31:0] a, d, rd; logic err; int cyc; bit exp_err;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; d = $urandom;
      exp_err = mdl_write(1'b1, a, d);
      xfer(1'b1, 1'b1, a, d, rd, err, cyc);
      n_tests++;
      if (err !== exp_err || cyc != 4) begin
        n_fail++; $display("FAIL ws3_write a=%h got err=%b cyc=%0d required err=%b cyc=4", a, err, cyc, exp_err);
      end
      xfer(1'b1, 1'b0, a, 32'h0, rd, err, cyc);
      n_tests++;
      if (rd !== mdl_read(1'b1, a) || err !== 1'b0 || cyc != 4) begin
        n_fail++; $display("FAIL ws3_b2b_read a=%h got %h cyc=%0d required %h cyc=4", a, rd, cyc, mdl_read(1'b1, a));
      end
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int cyc;
    idle(1);
    r_sel = 1'b0; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1;
    m_paddr = 32'h10; m_pwdata = 32'hDEADBEEF;
    @(posedge pclk); #1;
    m_penable = 1'b1;
    @(negedge pclk);
    preset = 1'b1;
    #1;
    n_tests++;
    if ({if0.pready, if0.pslverr, full0, full3} !== 4'b0 || if0.prdata !== 32'h0) begin
      n_fail++; $display("FAIL midrst_outputs got rdy/err/f0/f3=%b prdata=%h required 0000/0",
        {if0.pready, if0.pslverr, full0, full3}, if0.prdata);
    end
    @(posedge pclk); #1;
    idle(1);
    preset = 1'b0;
    m0.delete();
    m3.delete();
    idle(1);
    xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, err, cyc);
    n_tests++;
    if (rd !== 32'h0 || err !== 1'b0 || full0 !== 1'b0) begin
      n_fail++; $display("FAIL midrst_read got %h err=%b full=%b required 0 0 0", rd, err, full0);
    end
    idle(1);
  endtask

  task automatic test_random(input bit sel);
    logic [31:0] pool [10];
    logic [31:0] a, d, rd; logic err; int cyc; bit exp_err;
    foreach (pool[i]) pool[i] = $urandom;
    for (int i = 0; i < 20; i++) begin
      a = pool[$urandom_range(0, 9)]; d = $urandom;
      exp_err = mdl_write(sel, a, d);
      xfer(sel, 1'b1, a, d, rd, err, cyc);
      n_tests++;
      if (err !== exp_err) begin
        n_fail++; $display("FAIL rnd_write sel=%0d a=%h got err=%b required %b", sel, a, err, exp_err);
      end
      idle($urandom_range(0, 2));
    end
    foreach (pool[i]) begin
      xfer(sel, 1'b0, pool[i], 32'h0, rd, err, cyc);
      n_tests++;
      if (rd !== mdl_read(sel, pool[i]) || err !== 1'b0) begin
        n_fail++; $display("FAIL rnd_read sel=%0d a=%h got %h required %h", sel, pool[i], rd, mdl_read(sel, pool[i]));
      end
    end
    idle(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_overwrite_alias();
    test_capacity();
    test_wait3();
    test_reset_mid();
    test_random(1'b0);
    test_random(1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/amba3_apb_cam_slave.md
Name: amba3_apb_cam_slave

Overview:
AMBA 3 APB (v1.0) completer that stores 32-bit data against arbitrary full 32-bit addresses in a small fully-associative store, modelled as a CAM of {valid, address tag, data} entries. Any address, including unaligned ones (0x3, 0x11, 0x83), is a distinct key. It sits behind an APB master or bridge as a sparse scratch memory, with a programmable wait-state count.

Parameters:
ADDR_SIZE, 32, paddr width and CAM tag width.
DATA_SIZE, 32, pwdata/prdata width.
ENTRIES, 16, number of CAM entries (>=1).
WAIT_STATES, 0, extra access-phase cycles before pready asserts (0..15).

Ports:
pclk  input  1  APB clock; all state changes on rising edge.
preset  input  1  Reset. Interface: one clock; reset is asynchronous and active-high.
psel  input  1  Slave select.
penable  input  1  Access-phase strobe.
pwrite  input  1  1 = write, 0 = read.
paddr  input  ADDR_SIZE  Transfer address, used unmodified as the CAM key.
pwdata  input  DATA_SIZE  Write data.
prdata  output  DATA_SIZE  Read data.
pready  output  1  Transfer-complete strobe.
pslverr  output  1  Error response, valid only when pready=1.
full  output  1  High when all ENTRIES are valid.

Behaviour:
- Reset (async assert, sync release): all valid bits cleared, wait counter = 0; outputs prdata=0, pready=0, pslverr=0, full=0. Tag and data contents do not need resetting.
- Phases: setup = psel & !penable; access = psel & penable. penable without psel is ignored.
- Wait counter:
  - increments each access-phase cycle while below WAIT_STATES;
  - clears when a transfer completes or when psel=0.
- pready = access & (cnt == WAIT_STATES), combinational. WAIT_STATES=0 gives zero-wait, 2-cycle transfers.
- Outside completing cycles: pready=0, pslverr=0, prdata=0.
- Lookup: hit = some valid entry whose tag equals paddr. At most one entry can match.
- Write completion (rising edge with access & pready & pwrite):
  - hit: overwrite that entry's data with pwdata;
  - miss with a free entry: allocate the lowest-index invalid entry (tag=paddr, data=pwdata, valid=1);
  - miss with the CAM full: no state change, pslverr=1 in that completion cycle.
- Read completion (access & pready & !pwrite):
  - hit: prdata = entry data, combinational from the lookup;
  - miss: prdata=0, pslverr=0.
  - Reads never alter state.
- Signal stability: paddr, pwrite and pwdata are held stable by the master through the access phase. The slave samples only in the completion cycle.
- full = AND of all valid bits, registered state.
- Entries are never freed except by reset.
- Back-to-back transfers (setup directly after completion) are supported with no idle cycle. A write followed immediately by a read of the same address returns the new data.
- Reset asserted mid-transfer: the transfer aborts, nothing is committed, and all outputs go to their reset values immediately.

Test Plan:
- WAIT_STATES=0: write 0x0←0x4, 0x3←0x8, 0x11←0x14, 0x18←0x1C with random 0–10 idle cycles between; read back → 0x4, 0x8, 0x14, 0x1C, pslverr=0. pready must be high in the first access cycle.
- Overwrite: write 0x40←0x12345678, 0x83←0x40506070, 0x18←0x22446688 back-to-back. Read 0x18, 0x40, 0x83 → 0x22446688, 0x12345678, 0x40506070; occupancy stays at 6 entries.
- Aliasing: write 0x00000003←0xA, then 0x80000003←0xB. Reads return 0xA and 0xB respectively.
- Capacity: fill ENTRIES distinct random addresses → full=1. One more new-address write → pslverr=1, and all prior reads still correct. Writing an existing address still succeeds with pslverr=0. A read of a never-written address → prdata=0, pslverr=0.
- WAIT_STATES=3: every transfer's access phase lasts exactly 4 cycles, and data is correct.
- Reset: assert preset during an access-phase write to 0x10; after release, read 0x10 → 0, full=0. Randomised run of N writes followed by readback of all written addresses matches a reference model.
